// File: rtl/l2_input_sched_pkg.sv
// Shared types for the L2 input scheduler: FSM state encoding, starvation
// counter width and the bit positions of the per-channel grant vector.
// No ports; imported by l2_input_sched and l2_sched_prio.
package l2_input_sched_pkg;

    localparam int STARVE_CNT_BITS = 8;

    typedef enum logic [1:0] {
        SCHED_IDLE       = 2'd0,
        SCHED_BUSY       = 2'd1,
        SCHED_FLUSH_STEP = 2'd2
    } sched_state_t;

    // Bit positions inside the 4-bit eligibility / grant vectors.
    localparam int N_CHAN    = 4;
    localparam int GNT_RSP   = 3;
    localparam int GNT_FWD   = 2;
    localparam int GNT_FLUSH = 1;
    localparam int GNT_CPU   = 0;

endpackage

// File: rtl/l2_sched_prio.sv
// Purpose: combinational fixed-priority encoder rsp > fwd > flush > cpu, with a starved cpu promoted to just below rsp.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is used.
// Ports: elig_i  per-channel eligibility (bit positions from the package)
//        starve_i cpu starvation flag
//        grant_o  one-hot grant (all zero when nothing is eligible)
module l2_sched_prio
    import l2_input_sched_pkg::*;
(
    input  logic [N_CHAN-1:0] elig_i,
    input  logic              starve_i,
    output logic [N_CHAN-1:0] grant_o
);

    always_comb begin
        grant_o = '0;
        if (elig_i[GNT_RSP]) begin
            // Responses always win so the protocol can never deadlock.
            grant_o[GNT_RSP] = 1'b1;
        end else if (starve_i && elig_i[GNT_CPU]) begin
            grant_o[GNT_CPU] = 1'b1;
        end else if (elig_i[GNT_FWD]) begin
            grant_o[GNT_FWD] = 1'b1;
        end else if (elig_i[GNT_FLUSH]) begin
            grant_o[GNT_FLUSH] = 1'b1;
        end else if (elig_i[GNT_CPU]) begin
            grant_o[GNT_CPU] = 1'b1;
        end
    end

endmodule

// File: rtl/l2_input_sched.sv
// Purpose: L2 input scheduler; issues one request at a time (rsp/fwd/flush/cpu) to the decode datapath and walks flushes line by line.
// Latency: *_ready in the grant cycle, matching do_* registered one cycle later; next grant only after proc_done.
// Backpressure: channels wait on valid until their one-cycle ready; blocking inputs only gate eligibility in IDLE/FLUSH_STEP.
// Ports: clk/rst (async active-low); *_valid/*_ready channel handshakes; fwd_stall, set_conflict, evict_stall,
//        ongoing_atomic blocking inputs; flush_line_last, proc_done from the datapath; do_* one-hot selects,
//        ongoing_flush walk flag and idle status to the core FSM.
module l2_input_sched
    import l2_input_sched_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic clk,
    input  logic rst,

    input  logic l2_rsp_in_valid,
    input  logic l2_fwd_in_valid,
    input  logic l2_cpu_req_valid,
    input  logic l2_flush_valid,
    output logic l2_rsp_in_ready,
    output logic l2_fwd_in_ready,
    output logic l2_cpu_req_ready,
    output logic l2_flush_ready,

    input  logic fwd_stall,
    input  logic set_conflict,
    input  logic evict_stall,
    input  logic ongoing_atomic,
    input  logic flush_line_last,
    input  logic proc_done,

    output logic do_rsp,
    output logic do_fwd,
    output logic do_flush,
    output logic do_ongoing_flush,
    output logic do_cpu_req,
    output logic ongoing_flush,
    output logic idle
);

    localparam logic [STARVE_CNT_BITS-1:0] STARVE_MAX_C = STARVE_CNT_BITS'(STARVE_MAX);

    sched_state_t               state_q;
    logic                       armed_q;
    logic                       do_rsp_q;
    logic                       do_fwd_q;
    logic                       do_flush_q;
    logic                       do_oflush_q;
    logic                       do_cpu_q;
    logic                       ongoing_flush_q;
    logic [STARVE_CNT_BITS-1:0] starve_cnt_q;
    logic [STARVE_CNT_BITS-1:0] starve_cnt_d;

    logic [N_CHAN-1:0] elig;
    logic [N_CHAN-1:0] prio_gnt;
    logic [N_CHAN-1:0] gnt;

    always_comb begin
        elig            = '0;
        elig[GNT_RSP]   = l2_rsp_in_valid;
        elig[GNT_FWD]   = l2_fwd_in_valid & ~fwd_stall & ~ongoing_atomic;
        elig[GNT_FLUSH] = l2_flush_valid & ~ongoing_flush_q;
        elig[GNT_CPU]   = l2_cpu_req_valid & ~set_conflict & ~evict_stall
                        & ~ongoing_atomic & ~ongoing_flush_q;
    end

    l2_sched_prio u_prio (
        .elig_i   (elig),
        .starve_i (starve_cnt_q == STARVE_MAX_C),
        .grant_o  (prio_gnt)
    );

    // armed_q keeps every ready low while rst is asserted and for the first
    // cycle after release, without pulling the async reset into comb logic.
    always_comb begin
        gnt = '0;
        if (armed_q) begin
            case (state_q)
                SCHED_IDLE:       gnt = prio_gnt;
                // Mid-walk only responses may cut in; everything else waits.
                SCHED_FLUSH_STEP: gnt[GNT_RSP] = elig[GNT_RSP];
                default:          gnt = '0;
            endcase
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!l2_cpu_req_valid || gnt[GNT_CPU]) begin
            starve_cnt_d = '0;
        end else if (elig[GNT_CPU] && (|gnt) && (starve_cnt_q < STARVE_MAX_C)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= SCHED_IDLE;
            armed_q         <= 1'b0;
            do_rsp_q        <= 1'b0;
            do_fwd_q        <= 1'b0;
            do_flush_q      <= 1'b0;
            do_oflush_q     <= 1'b0;
            do_cpu_q        <= 1'b0;
            ongoing_flush_q <= 1'b0;
            starve_cnt_q    <= '0;
        end else begin
            armed_q      <= 1'b1;
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                SCHED_IDLE: begin
                    if (|gnt) begin
                        do_rsp_q   <= gnt[GNT_RSP];
                        do_fwd_q   <= gnt[GNT_FWD];
                        do_flush_q <= gnt[GNT_FLUSH];
                        do_cpu_q   <= gnt[GNT_CPU];
                        if (gnt[GNT_FLUSH]) begin
                            ongoing_flush_q <= 1'b1;
                        end
                        state_q <= SCHED_BUSY;
                    end
                end
                SCHED_FLUSH_STEP: begin
                    if (gnt[GNT_RSP]) begin
                        do_rsp_q <= 1'b1;
                    end else begin
                        do_oflush_q <= 1'b1;
                    end
                    state_q <= SCHED_BUSY;
                end
                SCHED_BUSY: begin
                    if (proc_done) begin
                        do_rsp_q    <= 1'b0;
                        do_fwd_q    <= 1'b0;
                        do_flush_q  <= 1'b0;
                        do_oflush_q <= 1'b0;
                        do_cpu_q    <= 1'b0;
                        if (do_flush_q) begin
                            state_q <= SCHED_FLUSH_STEP;
                        end else if (do_oflush_q) begin
                            if (flush_line_last) begin
                                ongoing_flush_q <= 1'b0;
                                state_q         <= SCHED_IDLE;
                            end else begin
                                state_q <= SCHED_FLUSH_STEP;
                            end
                        end else if (ongoing_flush_q) begin
                            // A response served mid-walk resumes the walk.
                            state_q <= SCHED_FLUSH_STEP;
                        end else begin
                            state_q <= SCHED_IDLE;
                        end
                    end
                end
                default: state_q <= SCHED_IDLE;
            endcase
        end
    end

    assign l2_rsp_in_ready  = gnt[GNT_RSP];
    assign l2_fwd_in_ready  = gnt[GNT_FWD];
    assign l2_flush_ready   = gnt[GNT_FLUSH];
    assign l2_cpu_req_ready = gnt[GNT_CPU];

    assign do_rsp           = do_rsp_q;
    assign do_fwd           = do_fwd_q;
    assign do_flush         = do_flush_q;
    assign do_ongoing_flush = do_oflush_q;
    assign do_cpu_req       = do_cpu_q;
    assign ongoing_flush    = ongoing_flush_q;
    assign idle             = armed_q & (state_q == SCHED_IDLE) & ~ongoing_flush_q;

endmodule

// File: tb/tb_l2_input_sched.sv
// Directed bench for l2_input_sched built with STARVE_MAX=3: arbitration order,
// starvation promotion, stalls, atomics, a 4-line flush walk and async reset.
module tb_l2_input_sched;

    localparam logic [3:0] R_RSP = 4'b1000;
    localparam logic [3:0] R_FWD = 4'b0100;
    localparam logic [3:0] R_FLS = 4'b0010;
    localparam logic [3:0] R_CPU = 4'b0001;
    localparam logic [4:0] D_RSP = 5'b10000;
    localparam logic [4:0] D_FWD = 5'b01000;
    localparam logic [4:0] D_FLS = 5'b00100;
    localparam logic [4:0] D_OF  = 5'b00010;
    localparam logic [4:0] D_CPU = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rsp_v = 1'b0, fwd_v = 1'b0, cpu_v = 1'b0, fls_v = 1'b0;
    logic rsp_r, fwd_r, cpu_r, fls_r;
    logic fwd_stall = 1'b0, set_conflict = 1'b0, evict_stall = 1'b0, ongoing_atomic = 1'b0;
    logic flush_line_last = 1'b0, proc_done = 1'b0;
    logic do_rsp, do_fwd, do_flush, do_oflush, do_cpu, ongoing_flush, idle;
    logic [3:0] rdy_vec;
    logic [4:0] do_vec;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rdy_vec = {rsp_r, fwd_r, fls_r, cpu_r};
    assign do_vec  = {do_rsp, do_fwd, do_flush, do_oflush, do_cpu};

    l2_input_sched #(.STARVE_MAX(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .l2_rsp_in_valid  (rsp_v),
        .l2_fwd_in_valid  (fwd_v),
        .l2_cpu_req_valid (cpu_v),
        .l2_flush_valid   (fls_v),
        .l2_rsp_in_ready  (rsp_r),
        .l2_fwd_in_ready  (fwd_r),
        .l2_cpu_req_ready (cpu_r),
        .l2_flush_ready   (fls_r),
        .fwd_stall        (fwd_stall),
        .set_conflict     (set_conflict),
        .evict_stall      (evict_stall),
        .ongoing_atomic   (ongoing_atomic),
        .flush_line_last  (flush_line_last),
        .proc_done        (proc_done),
        .do_rsp           (do_rsp),
        .do_fwd           (do_fwd),
        .do_flush         (do_flush),
        .do_ongoing_flush (do_oflush),
        .do_cpu_req       (do_cpu),
        .ongoing_flush    (ongoing_flush),
        .idle             (idle)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge. Waits (bounded) for a ready, checks which one, then
    // checks the do_* select one cycle later and completes it with proc_done.
    task automatic serve(input string tag, input logic [3:0] exp_rdy,
                         input logic [4:0] exp_do, input bit keep_valid);
        int k = 0;
        logic [3:0] got;
        while (rdy_vec == 4'b0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        got = rdy_vec;
        chk({tag, "_rdy"}, 32'(got), 32'(exp_rdy));
        @(posedge clk); #1;
        if (!keep_valid) begin
            if (got[3]) rsp_v = 1'b0;
            if (got[2]) fwd_v = 1'b0;
            if (got[1]) fls_v = 1'b0;
            if (got[0]) cpu_v = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_do"}, 32'(do_vec), 32'(exp_do));
        proc_done = 1'b1;
        @(posedge clk); #1;
        proc_done = 1'b0;
        @(negedge clk);
        chk({tag, "_doclr"}, 32'(do_vec), 32'd0);
    endtask

    // Called at a negedge in FLUSH_STEP; one walk line through the datapath.
    task automatic walk_step(input string tag, input bit last, input bit inject_rsp);
        @(negedge clk);
        chk({tag, "_do"}, 32'(do_vec), 32'(D_OF));
        proc_done       = 1'b1;
        flush_line_last = last;
        if (inject_rsp) rsp_v = 1'b1;
        @(posedge clk); #1;
        proc_done       = 1'b0;
        flush_line_last = 1'b0;
        @(negedge clk);
        chk({tag, "_doclr"}, 32'(do_vec), 32'd0);
        chk({tag, "_ong"}, 32'(ongoing_flush), last ? 32'd0 : 32'd1);
        if (!last && !inject_rsp) chk({tag, "_cpublk"}, 32'(cpu_r), 32'd0);
    endtask

    initial begin
        // Reset state, with a valid present to show readies are held off.
        rsp_v = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(rdy_vec), 32'd0);
        chk("rst_do", 32'(do_vec), 32'd0);
        chk("rst_ongoing", 32'(ongoing_flush), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);
        rsp_v = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_rst", 32'(idle), 32'd1);

        // rsp > fwd > cpu.
        @(posedge clk); #1;
        rsp_v = 1'b1; fwd_v = 1'b1; cpu_v = 1'b1;
        @(negedge clk);
        serve("t1_rsp", R_RSP, D_RSP, 1'b0);
        serve("t1_fwd", R_FWD, D_FWD, 1'b0);
        serve("t1_cpu", R_CPU, D_CPU, 1'b0);
        chk("t1_idle", 32'(idle), 32'd1);

        // Starvation: three fwd wins, then cpu jumps the pending fwd.
        @(posedge clk); #1;
        fwd_v = 1'b1; cpu_v = 1'b1;
        @(negedge clk);
        serve("t2_fwd1", R_FWD, D_FWD, 1'b1);
        serve("t2_fwd2", R_FWD, D_FWD, 1'b1);
        serve("t2_fwd3", R_FWD, D_FWD, 1'b1);
        chk("t2_starve_sat", 32'(dut.starve_cnt_q), 32'd3);
        serve("t2_cpu", R_CPU, D_CPU, 1'b0);
        chk("t2_starve_clr", 32'(dut.starve_cnt_q), 32'd0);
        serve("t2_fwd4", R_FWD, D_FWD, 1'b0);

        // fwd_stall lets cpu through; fwd follows once the stall drops.
        @(posedge clk); #1;
        fwd_stall = 1'b1; fwd_v = 1'b1; cpu_v = 1'b1;
        @(negedge clk);
        serve("t3_cpu", R_CPU, D_CPU, 1'b0);
        chk("t3_stall_hold", 32'(rdy_vec), 32'd0);
        @(posedge clk); #1;
        fwd_stall = 1'b0;
        @(negedge clk);
        serve("t3_fwd", R_FWD, D_FWD, 1'b0);

        // ongoing_atomic: only rsp may proceed.
        @(posedge clk); #1;
        ongoing_atomic = 1'b1; rsp_v = 1'b1; fwd_v = 1'b1; cpu_v = 1'b1;
        @(negedge clk);
        serve("t4_rsp", R_RSP, D_RSP, 1'b0);
        chk("t4_atom_blk0", 32'(rdy_vec), 32'd0);
        @(negedge clk);
        chk("t4_atom_blk1", 32'(rdy_vec), 32'd0);
        @(posedge clk); #1;
        ongoing_atomic = 1'b0;
        @(negedge clk);
        serve("t4_fwd", R_FWD, D_FWD, 1'b0);
        serve("t4_cpu", R_CPU, D_CPU, 1'b0);

        // 4-line flush walk with a response injected mid-walk; cpu waits.
        @(posedge clk); #1;
        fls_v = 1'b1; cpu_v = 1'b1;
        @(negedge clk);
        serve("t5_flush", R_FLS, D_FLS, 1'b0);
        chk("t5_ong_set", 32'(ongoing_flush), 32'd1);
        chk("t5_not_idle", 32'(idle), 32'd0);
        walk_step("t5_line2", 1'b0, 1'b1);
        serve("t5_rsp_mid", R_RSP, D_RSP, 1'b0);
        chk("t5_ong_after_rsp", 32'(ongoing_flush), 32'd1);
        walk_step("t5_line3", 1'b0, 1'b0);
        walk_step("t5_line4", 1'b1, 1'b0);
        serve("t5_cpu", R_CPU, D_CPU, 1'b0);

        // Async reset while do_cpu_req is held, then re-grant of the cpu.
        @(posedge clk); #1;
        cpu_v = 1'b1;
        @(negedge clk);
        chk("t6_rdy", 32'(rdy_vec), 32'(R_CPU));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_busy", 32'(do_vec), 32'(D_CPU));
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_do", 32'(do_vec), 32'd0);
        chk("t6_rst_rdy", 32'(rdy_vec), 32'd0);
        chk("t6_rst_idle", 32'(idle), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        serve("t6_regrant", R_CPU, D_CPU, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
